ram_arbiter: RTL and testbench

// - Shares the single-port, word-addressed ram between two requesters:

---
 rtl/ram_pkg.sv | 30 +++
 rtl/ram_arb_pick.sv | 45 ++++
 rtl/ram_arbiter.sv | 111 +++++++++++
 tb/tb_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the two-port ram arbiter (data port 0, fetch port 1).
// Includes the 33-bit range check helper used by the top-level address decode.
package ram_pkg;

  localparam int RAM_WORD_W = 32;

  localparam logic PORT_DATA  = 1'b0;
  localparam logic PORT_FETCH = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [31:0]           addr;
    logic [3:0]            be;
    logic [RAM_WORD_W-1:0] wdata;
  } ram_req_t;

  // Widened to 33 bits so a window ending at 2^32 cannot wrap to zero.
  function automatic logic addr_in_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [32:0] span_bytes
  );
    logic [32:0] lo;
    logic [32:0] a;
    lo = {1'b0, base};
    a  = {1'b0, addr};
    return (a >= lo) && (a < (lo + span_bytes));
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Two-way grant selection for the ram arbiter.
// ARB_ROUND_ROBIN_EN defined: alternate on conflict; otherwise port 0 has fixed priority.
module ram_arb_pick
  import ram_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic clock,
  input  logic reset_n,
`endif
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

`ifdef ARB_ROUND_ROBIN_EN
  // Port that received the most recent grant; starts as fetch so data wins first.
  logic last_port;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (last_port == PORT_DATA) gnt1 = 1'b1;
      else                        gnt0 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (!reset_n)
      last_port <= PORT_FETCH;
    else if (gnt0 || gnt1)
      last_port <= gnt1 ? PORT_FETCH : PORT_DATA;
  end
`else
  assign gnt0 = req0;
  assign gnt1 = req1 & ~req0;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port word-addressed ram between a data port (0) and a fetch port (1).
// Arbitration mode selected by ARB_ROUND_ROBIN_EN (round robin) or fixed port-0 priority.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter logic [31:0] OFFSET = 32'h0000_0000,
  parameter int unsigned SIZE   = 65536
) (
  input  logic                  clock,
  input  logic                  reset_n,

  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [31:0]           p0_addr,
  input  logic [3:0]            p0_be,
  input  logic [RAM_WORD_W-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [RAM_WORD_W-1:0] p0_rdata,
  output logic                  p0_err,

  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [31:0]           p1_addr,
  input  logic [3:0]            p1_be,
  input  logic [RAM_WORD_W-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [RAM_WORD_W-1:0] p1_rdata,
  output logic                  p1_err,

  output logic                  ram_read,
  output logic                  ram_write,
  output logic [31:0]           ram_address,
  output logic [3:0]            ram_byteenable,
  output logic [RAM_WORD_W-1:0] ram_wdata,
  input  logic [RAM_WORD_W-1:0] ram_rdata
);

  localparam logic [32:0] SPAN_BYTES = 33'(SIZE) << 2;

  ram_req_t req0, req1, cur;
  logic     req0_live, req1_live;
  logic     gnt0, gnt1, granted, sel_port, in_range;

  assign req0 = {p0_we, p0_addr, p0_be, p0_wdata};
  assign req1 = {p1_we, p1_addr, p1_be, p1_wdata};

  // Requests are masked during reset so no grant or ram strobe can escape.
  assign req0_live = p0_req & reset_n;
  assign req1_live = p1_req & reset_n;

  ram_arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .clock   (clock),
    .reset_n (reset_n),
`endif
    .req0    (req0_live),
    .req1    (req1_live),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  assign p0_gnt  = gnt0;
  assign p1_gnt  = gnt1;
  assign granted = gnt0 | gnt1;

  // An idle cycle selects port 0, so the ram bus then mirrors port 0's inputs.
  assign sel_port = gnt1 ? PORT_FETCH : PORT_DATA;
  assign cur      = (sel_port == PORT_FETCH) ? req1 : req0;
  assign in_range = addr_in_range(cur.addr, OFFSET, SPAN_BYTES);

  assign ram_read       = granted & ~cur.we & in_range;
  assign ram_write      = granted &  cur.we & in_range;
  assign ram_address    = (cur.addr - OFFSET) >> 2;
  assign ram_byteenable = cur.be;
  assign ram_wdata      = cur.wdata;

  // Response tracking: one slot suffices because the ram answers in exactly one cycle.
  logic rsp_read;
  logic rsp_err;
  logic rsp_port;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_read <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_port <= PORT_DATA;
    end else begin
      rsp_read <= granted & ~cur.we;
      rsp_err  <= granted & ~in_range;
      rsp_port <= sel_port;
    end
  end

  logic [RAM_WORD_W-1:0] rsp_data;

  // Out-of-range reads never strobed the ram, so its stale output must be masked.
  assign rsp_data = rsp_err ? '0 : ram_rdata;

  assign p0_rvalid = rsp_read & (rsp_port == PORT_DATA);
  assign p1_rvalid = rsp_read & (rsp_port == PORT_FETCH);
  assign p0_err    = rsp_err  & (rsp_port == PORT_DATA);
  assign p1_err    = rsp_err  & (rsp_port == PORT_FETCH);
  assign p0_rdata  = p0_rvalid ? rsp_data : '0;
  assign p1_rdata  = p1_rvalid ? rsp_data : '0;

  a_one_grant : assert property (@(posedge clock) disable iff (!reset_n) !(gnt0 && gnt1));
  a_one_strobe : assert property (@(posedge clock) disable iff (!reset_n) !(ram_read && ram_write));

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural ram, shadow memory and response scoreboard.
// Expected grant order depends on whether ARB_ROUND_ROBIN_EN is defined.
module tb_ram_arbiter;
  import ram_pkg::*;

  localparam logic [31:0] OFFSET = 32'h0000_0000;
  localparam int          SIZE   = 1024;
  localparam int          AW     = $clog2(SIZE);
  localparam logic [31:0] LIMIT  = OFFSET + 32'(SIZE) * 4;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  ram_req_t r0, r1;
  logic     q0, q1;

  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        ram_read, ram_write;
  logic [31:0] ram_address, ram_wdata, ram_rdata;
  logic [3:0]  ram_byteenable;

  ram_arbiter #(.OFFSET(OFFSET), .SIZE(SIZE)) dut (
    .clock(clock), .reset_n(reset_n),
    .p0_req(q0), .p0_we(r0.we), .p0_addr(r0.addr), .p0_be(r0.be), .p0_wdata(r0.wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(q1), .p1_we(r1.we), .p1_addr(r1.addr), .p1_be(r1.be), .p1_wdata(r1.wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
    .ram_byteenable(ram_byteenable), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] seed_word(input int i);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h9E37_79B1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = wd[8*b +: 8];
    return m;
  endfunction

  function automatic ram_req_t rd(input logic [31:0] addr);
    return '{we: 1'b0, addr: addr, be: 4'hF, wdata: 32'h0};
  endfunction

  function automatic ram_req_t wr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    return '{we: 1'b1, addr: addr, be: be, wdata: wd};
  endfunction

  // Behavioural ram: strobes latched mid-cycle, applied at the edge; index aliases like real hardware.
  logic [31:0] mem [SIZE];
  initial begin
    logic          s_rd, s_wr;
    logic [AW-1:0] s_idx;
    logic [3:0]    s_be;
    logic [31:0]   s_wd;
    for (int i = 0; i < SIZE; i++) mem[i] = seed_word(i);
    mem[4] = 32'hCAFE_F00D;
    mem[2] = 32'hAABB_CCDD;
    ram_rdata = 32'h0;
    forever begin
      @(negedge clock);
      s_rd  = ram_read;
      s_wr  = ram_write;
      s_idx = ram_address[AW-1:0];
      s_be  = ram_byteenable;
      s_wd  = ram_wdata;
      @(posedge clock);
      if (s_wr) mem[s_idx] = merge(mem[s_idx], s_wd, s_be);
      if (s_rd) ram_rdata <= mem[s_idx];
    end
  end

  typedef struct {
    bit          port;
    bit          is_read;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] gnt_log[$];

  // Monitor: compares responses against the scoreboard and checks each grant's ram bus.
  logic [31:0] shadow [SIZE];
  initial begin
    int          cyc;
    exp_t        e;
    ram_req_t    g;
    bit          gp, inr;
    logic [31:0] word;
    logic [3:0]  ev;
    cyc = 0;
    for (int i = 0; i < SIZE; i++) shadow[i] = seed_word(i);
    shadow[4] = 32'hCAFE_F00D;
    shadow[2] = 32'hAABB_CCDD;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        exp_q.delete();
        check("reset_outputs", {p0_gnt, p1_gnt, ram_read, ram_write, p0_rvalid, p1_rvalid, p0_err, p1_err}, 0);
        check("reset_rdata", {p0_rdata, p1_rdata}, 0);
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e  = exp_q.pop_front();
          ev = {e.is_read && !e.port, e.err && !e.port, e.is_read && e.port, e.err && e.port};
          check("rsp_flags", {p0_rvalid, p0_err, p1_rvalid, p1_err}, ev);
          check("rsp_p0_rdata", p0_rdata, (e.is_read && !e.port) ? e.data : 32'h0);
          check("rsp_p1_rdata", p1_rdata, (e.is_read &&  e.port) ? e.data : 32'h0);
        end else begin
          check("quiet_flags", {p0_rvalid, p0_err, p1_rvalid, p1_err}, 0);
          check("quiet_rdata", {p0_rdata, p1_rdata}, 0);
        end
        check("single_grant", p0_gnt & p1_gnt, 0);
        if (p0_gnt || p1_gnt) begin
          gnt_log.push_back({p1_gnt, p0_gnt});
          gp   = p1_gnt;
          g    = gp ? r1 : r0;
          inr  = ({1'b0, g.addr} >= {1'b0, OFFSET}) && ({1'b0, g.addr} < {1'b0, LIMIT});
          word = (g.addr - OFFSET) >> 2;
          check("ram_read", ram_read, !g.we && inr);
          check("ram_write", ram_write, g.we && inr);
          if (inr) check("ram_address", ram_address, word);
          if (g.we && inr) begin
            check("ram_be", ram_byteenable, g.be);
            check("ram_wdata", ram_wdata, g.wdata);
            shadow[word[AW-1:0]] = merge(shadow[word[AW-1:0]], g.wdata, g.be);
          end
          if (!g.we)
            exp_q.push_back('{port: gp, is_read: 1'b1, data: inr ? shadow[word[AW-1:0]] : 32'h0, err: !inr, cyc: cyc + 1});
          else if (!inr)
            exp_q.push_back('{port: gp, is_read: 1'b0, data: 32'h0, err: 1'b1, cyc: cyc + 1});
        end else begin
          check("idle_strobes", {ram_read, ram_write}, 0);
          check("idle_address", ram_address, (r0.addr - OFFSET) >> 2);
          check("idle_wdata", {ram_byteenable, ram_wdata}, {r0.be, r0.wdata});
        end
      end
    end
  end

  // Raises one request, waits (bounded) for its grant, drops it right after the granting edge.
  task automatic issue(input bit port, input ram_req_t r, output int tries);
    bit done;
    done  = 1'b0;
    tries = 0;
    if (port) begin r1 = r; q1 = 1'b1; end
    else      begin r0 = r; q0 = 1'b1; end
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge clock);
      done = port ? p1_gnt : p0_gnt;
      tries++;
      @(posedge clock); #1;
    end
    if (port) q1 = 1'b0;
    else      q0 = 1'b0;
    if (!done) check("gnt_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset_n = 1'b0;
    q0 = 1'b0; q1 = 1'b0;
    r0 = rd(32'h0); r1 = rd(32'h0);
    repeat (2) @(posedge clock);
    #1;
    q0 = 1'b1; r0 = rd(32'h10);
    #1;
    check("rst_gnt_forced", {p0_gnt, p1_gnt, ram_read, ram_write}, 0);
    q0 = 1'b0; r0 = rd(32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Partial write, then an immediate read of the same word.
    issue(0, wr(32'h8, 4'b0011, 32'h1122_3344), t);
    issue(0, rd(32'h8), t);
    check("wr_rd_merge", p0_rdata, 32'hAABB_3344);

    // Lone fetch read: granted on the first cycle, data on port 1 only.
    issue(1, rd(32'h10), t);
    check("p1_gnt_latency", t, 1);
    check("p1_rdata", p1_rdata, 32'hCAFE_F00D);
    check("p1_rvalid_only", {p0_rvalid, p1_rvalid}, 2'b01);

    // Four cycles of conflict.
    gnt_log.delete();
    r0 = rd(32'h20); r1 = rd(32'h24);
    q0 = 1'b1; q1 = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    q0 = 1'b0; q1 = 1'b0;
    check("conflict_len", gnt_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      check($sformatf("conflict_gnt%0d", i), gnt_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      check($sformatf("conflict_gnt%0d", i), gnt_log[i], 2'b01);
`endif
    end
    @(posedge clock); #1;

    // Range boundaries: first out-of-range word, wrap-around address, last in-range word.
    issue(1, rd(LIMIT), t);
    check("oor_rd_flags", {p1_rvalid, p1_err, p1_rdata}, {2'b11, 32'h0});
    issue(0, wr(LIMIT, 4'hF, 32'hDEAD_BEEF), t);
    check("oor_wr_err", {p0_err, p0_rvalid}, 2'b10);
    issue(0, wr(32'hFFFF_FFFC, 4'hF, 32'h0BAD_C0DE), t);
    issue(1, rd(LIMIT - 32'h4), t);
    check("last_word", p1_rdata, seed_word(SIZE - 1));

    // Back-to-back reads alternating ports.
    issue(0, rd(32'h0), t);
    check("b2b_0", p0_rdata, seed_word(0));
    issue(1, rd(32'h4), t);
    check("b2b_1", p1_rdata, seed_word(1));
    issue(0, rd(32'h8), t);
    check("b2b_2", p0_rdata, 32'hAABB_3344);

    // Reset while a read response is in flight.
    issue(0, rd(32'h10), t);
    reset_n = 1'b0;
    #1;
    check("rst_flush_flags", {p0_rvalid, p1_rvalid, p0_err, p1_err}, 0);
    check("rst_flush_rdata", p0_rdata, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    gnt_log.delete();
    r0 = rd(32'h30); r1 = rd(32'h34);
    q0 = 1'b1; q1 = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    q0 = 1'b0; q1 = 1'b0;
    check("post_rst_len", gnt_log.size(), 2);
    check("post_rst_first", gnt_log[0], 2'b01);
`ifdef ARB_ROUND_ROBIN_EN
    check("post_rst_second", gnt_log[1], 2'b10);
`else
    check("post_rst_second", gnt_log[1], 2'b01);
`endif

    repeat (3) begin @(posedge clock); #1; end
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
